// File: rtl/wbuf_pkg.sv
// Shared types and helpers for the weight FIFO loader: state encoding, sizing
// function and the default group/beat-width constants.
package wbuf_pkg;

    localparam int DEF_LANES      = 8;
    localparam int DEF_BUFFER_NUM = 32;
    localparam int DEF_KMAX       = 16;

    // Smallest r with 2**r >= value; bounded loop so it stays a constant function.
    function automatic int clogb2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    localparam int G  = DEF_BUFFER_NUM / DEF_LANES;
    localparam int KW = clogb2(DEF_KMAX + 1);

    typedef enum logic [2:0] {IDLE, CMD, LOAD, DRAIN, DONE} state_t;

endpackage

// File: rtl/wb_addr_gen.sv
// Write-side beat walker: beat fastest, then weight, then group. The address
// simply increments inside a group and restarts at the base on a group change.
module wb_addr_gen
    import wbuf_pkg::*;
#(
    parameter int ADDR_LEN   = 16,
    parameter int SINGLE_LEN = 24,
    parameter int KW_P       = 5,
    parameter int GROUPS     = 4,
    parameter int GW         = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  step,
    input  logic [ADDR_LEN-1:0]   base,
    input  logic [KW_P-1:0]       kk,
    input  logic [SINGLE_LEN-1:0] weight_num,
    output logic [ADDR_LEN-1:0]   addr,
    output logic [GW-1:0]         grp,
    output logic                  last
);

    logic [KW_P-1:0]       b_cnt;
    logic [SINGLE_LEN-1:0] w_cnt;
    logic                  beat_last;
    logic                  weight_last;
    logic                  group_last;

    assign beat_last   = (b_cnt == kk - KW_P'(1));
    assign weight_last = (w_cnt == weight_num - SINGLE_LEN'(1));
    assign group_last  = (grp == GW'(GROUPS - 1));
    assign last        = beat_last && weight_last && group_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_cnt <= '0;
            w_cnt <= '0;
            grp   <= '0;
            addr  <= '0;
        end else if (clr) begin
            b_cnt <= '0;
            w_cnt <= '0;
            grp   <= '0;
            addr  <= base;
        end else if (step) begin
            if (!beat_last) begin
                b_cnt <= b_cnt + KW_P'(1);
                addr  <= addr + ADDR_LEN'(1);
            end else begin
                b_cnt <= '0;
                if (!weight_last) begin
                    w_cnt <= w_cnt + SINGLE_LEN'(1);
                    addr  <= addr + ADDR_LEN'(1);
                end else begin
                    w_cnt <= '0;
                    grp   <= grp + GW'(1);
                    addr  <= base;
                end
            end
        end
    end

endmodule

// File: rtl/weight_fifo_loader.sv
// Streams DDR FIFO words into groups of weight-buffer banks. Reads are counted
// flat against the job total; writes are sequenced by wb_addr_gen two cycles later.
module weight_fifo_loader
    import wbuf_pkg::*;
#(
    parameter int DATA_LEN     = 64,
    parameter int LANES        = 8,
    parameter int BUFFER_NUM   = 32,
    parameter int ADDR_LEN     = 16,
    parameter int DDR_ADDR_LEN = 32,
    parameter int SINGLE_LEN   = 24,
    parameter int KMAX         = 16,
    localparam int KW_L        = clogb2(KMAX + 1),
    localparam int DW          = LANES * DATA_LEN
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    conf,
    input  logic                    abort,
    input  logic [SINGLE_LEN-1:0]   weight_num,
    input  logic [KW_L-1:0]         kk,
    input  logic [SINGLE_LEN-1:0]   weight_ddr_byte,
    input  logic [DDR_ADDR_LEN-1:0] ddr_st_addr,
    input  logic [ADDR_LEN-1:0]     wb_st_addr,
    output logic [DDR_ADDR_LEN-1:0] ddr_st_addr_out,
    output logic [SINGLE_LEN-1:0]   ddr_len,
    output logic                    ddr_conf,
    input  logic                    ddr_fifo_empty,
    output logic                    ddr_fifo_req,
    input  logic [DW-1:0]           ddr_fifo_data,
    output logic [ADDR_LEN-1:0]     wb_addr,
    output logic [DW-1:0]           wb_data,
    output logic [BUFFER_NUM-1:0]   wb_wea,
    output logic                    idle,
    output logic                    done
);

    localparam int NG = BUFFER_NUM / LANES;
    localparam int GW = (NG > 1) ? clogb2(NG) : 1;
    localparam int TW = SINGLE_LEN + clogb2(NG);

    state_t                  state;
    state_t                  state_next;
    logic [SINGLE_LEN-1:0]   wn_r;
    logic [KW_L-1:0]         kk_r;
    logic [ADDR_LEN-1:0]     wb_st_r;
    logic [DDR_ADDR_LEN-1:0] ddr_addr_r;
    logic [SINGLE_LEN-1:0]   len_r;
    logic                    zero_r;
    logic [TW-1:0]           total_r;
    logic [TW-1:0]           issued;
    logic                    rd_vld;
    logic                    wr_step;
    logic [ADDR_LEN-1:0]     gen_addr;
    logic [GW-1:0]           gen_grp;
    logic                    gen_last;
    logic [BUFFER_NUM-1:0]   grp_mask;

    assign ddr_fifo_req    = (state == LOAD) && !ddr_fifo_empty && (issued < total_r);
    assign ddr_conf        = (state == CMD) && !zero_r;
    assign idle            = (state == IDLE);
    assign done            = (state == DONE);
    assign ddr_st_addr_out = ddr_addr_r;
    assign ddr_len         = len_r;
    assign wr_step         = rd_vld && !abort;
    assign grp_mask        = BUFFER_NUM'({LANES{1'b1}}) << (int'(gen_grp) * LANES);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (conf) state_next = CMD;
            CMD:     state_next = zero_r ? DONE : LOAD;
            LOAD:    if (ddr_fifo_req && (issued == total_r - TW'(1))) state_next = DRAIN;
            DRAIN:   if (rd_vld && gen_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort && (state != IDLE)) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            wn_r       <= '0;
            kk_r       <= '0;
            wb_st_r    <= '0;
            ddr_addr_r <= '0;
            len_r      <= '0;
            zero_r     <= 1'b0;
            total_r    <= '0;
            issued     <= '0;
        end else begin
            state <= state_next;
            if ((state == IDLE) && conf) begin
                wn_r       <= weight_num;
                kk_r       <= kk;
                wb_st_r    <= wb_st_addr;
                ddr_addr_r <= ddr_st_addr;
                len_r      <= weight_ddr_byte;
                zero_r     <= (weight_num == '0) || (kk == '0);
                total_r    <= TW'(NG) * TW'(weight_num) * TW'(kk);
            end
            if (state == CMD) issued <= '0;
            else if (ddr_fifo_req) issued <= issued + TW'(1);
        end
    end

    // Data for a request taken in the abort cycle is dropped by clearing rd_vld.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_vld  <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
            wb_wea  <= '0;
        end else begin
            rd_vld <= ddr_fifo_req && !abort;
            if (wr_step) begin
                wb_addr <= gen_addr;
                wb_data <= ddr_fifo_data;
                wb_wea  <= grp_mask;
            end else begin
                wb_wea  <= '0;
            end
        end
    end

    wb_addr_gen #(
        .ADDR_LEN  (ADDR_LEN),
        .SINGLE_LEN(SINGLE_LEN),
        .KW_P      (KW_L),
        .GROUPS    (NG),
        .GW        (GW)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (state == CMD),
        .step      (wr_step),
        .base      (wb_st_r),
        .kk        (kk_r),
        .weight_num(wn_r),
        .addr      (gen_addr),
        .grp       (gen_grp),
        .last      (gen_last)
    );

endmodule

// File: tb/tb_weight_fifo_loader.sv
// Bench for weight_fifo_loader: table of jobs plus hand sequences for abort,
// reset, zero jobs and conf-while-busy, scored against an index-based model.
module tb_weight_fifo_loader;

    localparam int DW  = 512;
    localparam int NGR = 4;

    logic            clk;
    logic            rst_n;
    logic            conf;
    logic            abort;
    logic [23:0]     weight_num;
    logic [4:0]      kk;
    logic [23:0]     weight_ddr_byte;
    logic [31:0]     ddr_st_addr;
    logic [15:0]     wb_st_addr;
    logic [31:0]     ddr_st_addr_out;
    logic [23:0]     ddr_len;
    logic            ddr_conf;
    logic            ddr_fifo_empty;
    logic            ddr_fifo_req;
    logic [DW-1:0]   ddr_fifo_data;
    logic [15:0]     wb_addr;
    logic [DW-1:0]   wb_data;
    logic [31:0]     wb_wea;
    logic            idle;
    logic            done;

    weight_fifo_loader dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .conf           (conf),
        .abort          (abort),
        .weight_num     (weight_num),
        .kk             (kk),
        .weight_ddr_byte(weight_ddr_byte),
        .ddr_st_addr    (ddr_st_addr),
        .wb_st_addr     (wb_st_addr),
        .ddr_st_addr_out(ddr_st_addr_out),
        .ddr_len        (ddr_len),
        .ddr_conf       (ddr_conf),
        .ddr_fifo_empty (ddr_fifo_empty),
        .ddr_fifo_req   (ddr_fifo_req),
        .ddr_fifo_data  (ddr_fifo_data),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .wb_wea         (wb_wea),
        .idle           (idle),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          wn;
        int          kv;
        logic [15:0] st;
        logic [31:0] da;
        logic [23:0] nb;
        int          mode;
        int          exp_writes;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];
    int cyc = 0;
    int empty_mode = 0;
    int cur_wn = 0, cur_kk = 0, cur_st = 0;
    int writes_seen = 0, reqs_seen = 0, done_cnt = 0, conf_cnt = 0;
    int done_cyc = 0, last_req_cyc = 0;
    logic prev_req = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    // FIFO emulation and write scoreboard, acting mid-cycle.
    always @(negedge clk) begin
        logic [DW-1:0] word;
        logic [DW-1:0] ed;
        logic [15:0]   ea;
        logic [31:0]   ew;
        int wi, b, w, g;
        cyc++;
        if (|wb_wea) begin
            wi = writes_seen;
            if (cur_wn > 0 && cur_kk > 0) begin
                b  = wi % cur_kk;
                w  = (wi / cur_kk) % cur_wn;
                g  = wi / (cur_kk * cur_wn);
                ea = 16'(cur_st + w * cur_kk + b);
                ew = (g < NGR) ? (32'hFF << (8 * g)) : 32'h0;
                chk("wr_addr", DW'(wb_addr), DW'(ea));
                chk("wr_wea", DW'(wb_wea), DW'(ew));
                ed = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                chk("wr_data", wb_data, ed);
            end else begin
                chk("unexpected_write", DW'(wb_wea), '0);
            end
            writes_seen++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (ddr_conf) conf_cnt++;
        if (prev_req) begin
            for (int k = 0; k < DW / 32; k++) word[32*k +: 32] = $urandom;
            ddr_fifo_data = word;
            exp_q.push_back(word);
        end
        case (empty_mode)
            0:       ddr_fifo_empty = 1'b0;
            1:       ddr_fifo_empty = cyc[0];
            default: ddr_fifo_empty = ($urandom_range(0, 3) == 0);
        endcase
        #1;
        if (ddr_fifo_req) begin
            reqs_seen++;
            last_req_cyc = cyc;
            chk("req_while_empty", DW'(ddr_fifo_empty), '0);
        end
        prev_req = ddr_fifo_req;
    end

    task automatic start_conf(input int wn, input int kv, input logic [15:0] st,
                              input logic [31:0] da, input logic [23:0] nb);
        cur_wn = wn; cur_kk = kv; cur_st = int'(st);
        writes_seen = 0; reqs_seen = 0; done_cnt = 0; conf_cnt = 0;
        exp_q.delete();
        weight_num = 24'(wn); kk = 5'(kv); wb_st_addr = st;
        ddr_st_addr = da; weight_ddr_byte = nb;
        conf = 1'b1;
        tick();
        conf = 1'b0;
        chk("ddr_conf_after_conf", DW'(ddr_conf), DW'(wn != 0 && kv != 0));
        chk("ddr_st_addr_out", DW'(ddr_st_addr_out), DW'(da));
        chk("ddr_len", DW'(ddr_len), DW'(nb));
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) tick();
        chk("done_seen", DW'(done_cnt), DW'(1));
    endtask

    task automatic check_job_end(input int exp_writes, input bit nonzero);
        tick();
        chk("idle_after_done", DW'(idle), DW'(1));
        chk("done_one_cycle", DW'(done), '0);
        chk("write_count", DW'(writes_seen), DW'(exp_writes));
        chk("req_count", DW'(reqs_seen), DW'(exp_writes));
        chk("done_count", DW'(done_cnt), DW'(1));
        chk("ddr_conf_count", DW'(conf_cnt), DW'(nonzero));
        chk("leftover_data", DW'(exp_q.size()), '0);
        if (nonzero) chk("done_latency", DW'(done_cyc), DW'(last_req_cyc + 2));
    endtask

    task automatic run_vec(input vec_t v);
        empty_mode = v.mode;
        start_conf(v.wn, v.kv, v.st, v.da, v.nb);
        wait_done(3000);
        check_job_end(v.exp_writes, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_idle"}, DW'(idle), DW'(1));
        chk({tag, "_done"}, DW'(done), '0);
        chk({tag, "_ddr_conf"}, DW'(ddr_conf), '0);
        chk({tag, "_req"}, DW'(ddr_fifo_req), '0);
        chk({tag, "_wea"}, DW'(wb_wea), '0);
        chk({tag, "_addr"}, DW'(wb_addr), '0);
        chk({tag, "_data"}, wb_data, '0);
        chk({tag, "_ddr_addr"}, DW'(ddr_st_addr_out), '0);
        chk({tag, "_ddr_len"}, DW'(ddr_len), '0);
    endtask

    vec_t vecs[7];

    initial begin
        int w_at, r_at, wn_r, kk_r;
        rst_n = 1'b0; conf = 1'b0; abort = 1'b0;
        weight_num = '0; kk = '0; weight_ddr_byte = '0;
        ddr_st_addr = '0; wb_st_addr = '0;
        ddr_fifo_empty = 1'b1; ddr_fifo_data = '0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        vecs[0] = '{2, 9,  16'h0010, 32'h1000_0000, 24'd4608, 0, 72};
        vecs[1] = '{5, 1,  16'h0200, 32'h2000_0040, 24'd1280, 0, 20};
        vecs[2] = '{2, 9,  16'h0010, 32'h1000_0000, 24'd4608, 1, 72};
        vecs[3] = '{1, 4,  16'hFFFE, 32'h3000_0000, 24'd1024, 0, 16};
        vecs[4] = '{3, 16, 16'h0123, 32'h4000_0000, 24'd9999, 2, 192};
        for (int i = 5; i < 7; i++) begin
            wn_r = $urandom_range(1, 4);
            kk_r = $urandom_range(1, 16);
            vecs[i] = '{wn_r, kk_r, 16'($urandom), $urandom, 24'($urandom), 2, NGR * wn_r * kk_r};
        end
        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Abort after 20 reads, then a clean job.
        empty_mode = 0;
        start_conf(4, 9, 16'h0030, 32'h5000_0000, 24'd100);
        for (int i = 0; i < 500 && reqs_seen < 20; i++) tick();
        chk("abort_reached_20", DW'(reqs_seen >= 20), DW'(1));
        abort = 1'b1;
        w_at = writes_seen;
        r_at = reqs_seen;
        tick();
        abort = 1'b0;
        chk("abort_idle", DW'(idle), DW'(1));
        chk("abort_wea", DW'(wb_wea), '0);
        chk("abort_req", DW'(ddr_fifo_req), '0);
        repeat (10) tick();
        chk("abort_no_writes", DW'(writes_seen), DW'(w_at));
        chk("abort_no_reqs", DW'(reqs_seen), DW'(r_at));
        chk("abort_no_done", DW'(done_cnt), '0);
        run_vec(vecs[0]);

        // conf while busy is ignored.
        empty_mode = 0;
        start_conf(2, 3, 16'h0040, 32'h6000_0000, 24'd77);
        repeat (4) tick();
        weight_num = 24'd7; kk = 5'd2; wb_st_addr = 16'h0099;
        ddr_st_addr = 32'hDEAD_0000; weight_ddr_byte = 24'd5;
        conf = 1'b1;
        tick();
        conf = 1'b0;
        chk("busy_conf_ddr_addr", DW'(ddr_st_addr_out), DW'(32'h6000_0000));
        chk("busy_conf_ddr_len", DW'(ddr_len), DW'(24'd77));
        wait_done(3000);
        check_job_end(24, 1'b1);

        // Zero jobs: done pulse, no command, no reads.
        start_conf(0, 5, 16'h0000, 32'h7000_0000, 24'd0);
        wait_done(20);
        check_job_end(0, 1'b0);
        start_conf(3, 0, 16'h0000, 32'h7100_0000, 24'd8);
        wait_done(20);
        check_job_end(0, 1'b0);

        // Reset in the middle of a job.
        empty_mode = 0;
        start_conf(3, 7, 16'h0500, 32'h8000_0000, 24'd64);
        repeat (8) tick();
        rst_n = 1'b0;
        tick();
        check_reset_outputs("midjob_reset");
        rst_n = 1'b1;
        tick();
        run_vec(vecs[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
